htif_burst: RTL and testbench

- Parametrised successor host-interface bridge: a byte-serial host link (rx/tx valid-ready) drives a word-wide request/response bus.
- Adds configurable data/address width, counted bursts of 1..256 words, an optional write acknowledge byte, and an identify command.
- Sits between the UART/JTAG byte transport and the system bus master port, used for loading and inspecting memory.

---
 rtl/htif_burst.sv | 243 ++++++++++++++++++++++++
 tb/tb_htif_burst.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_burst.sv
// htif_burst: byte-serial host link driving a word-wide bus master port.
// Host commands: 'a' load address, 'r'/'w' counted bursts, '?' identify.
module htif_burst #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_BYTES = 4,
   parameter int ACK_WRITES = 1,
   localparam int DW = 8*DATA_BYTES,
   localparam int AW = 8*ADDR_BYTES
) (
   input  logic          clock,
   input  logic          reset,
   output logic          rx_ready,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          bus_req_ready,
   output logic          bus_req_read,
   output logic          bus_req_write,
   output logic [AW-1:0] bus_req_address,
   output logic [DW-1:0] bus_req_data,
   input  logic          bus_res_valid,
   input  logic [DW-1:0] bus_res_data,
   input  logic          tx_ready,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   output logic [3:0]    state
);

   typedef enum logic [3:0] {
      ST_START = 4'd0,
      ST_ADDR  = 4'd1,
      ST_LEN   = 4'd2,
      ST_WDATA = 4'd3,
      ST_WREQ  = 4'd4,
      ST_RREQ  = 4'd5,
      ST_RWAIT = 4'd6,
      ST_TX    = 4'd7,
      ST_ACK   = 4'd8,
      ST_ID    = 4'd9
   } state_e;

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } bus_req_t;

   localparam logic [7:0] CMD_ADDR  = 8'h61;  // 'a'
   localparam logic [7:0] CMD_READ  = 8'h72;  // 'r'
   localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
   localparam logic [7:0] CMD_ID    = 8'h3F;  // '?'
   localparam logic [7:0] ACK_BYTE  = 8'h6B;  // 'k'

   localparam logic [2:0] DB_LAST = 3'(DATA_BYTES-1);
   localparam logic [2:0] AB_LAST = 3'(ADDR_BYTES-1);
   localparam logic [AW-1:0] ADDR_STEP = AW'(DATA_BYTES);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;     // live bus address
   logic [AW-1:0] ash_q, ash_d;       // address being assembled from host bytes
   logic [DW-1:0] buf_q, buf_d;
   logic [7:0]    cnt_q, cnt_d;       // remaining words in burst minus one
   logic [2:0]    bcnt_q, bcnt_d;     // byte index within the current field
   logic          is_wr_q, is_wr_d;

   logic          rx_open;
   bus_req_t      req;

   // Output decode: everything is a function of the current state only, so
   // requests and tx bytes stay put until their handshake completes.
   always_comb begin
      rx_open  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      req      = '0;
      req.addr = addr_q;
      case (state_q)
         ST_START, ST_ADDR, ST_LEN, ST_WDATA: rx_open = 1'b1;
         ST_WREQ: begin
            req.wr   = 1'b1;
            req.data = buf_q;
         end
         ST_RREQ: req.rd = 1'b1;
         ST_TX: begin
            tx_valid = 1'b1;
            tx_data  = buf_q[7:0];
         end
         ST_ACK: begin
            tx_valid = 1'b1;
            tx_data  = ACK_BYTE;
         end
         ST_ID: begin
            tx_valid = 1'b1;
            tx_data  = (bcnt_q == 3'd0) ? 8'(DATA_BYTES) : 8'(ADDR_BYTES);
         end
         default: ;
      endcase
   end

   // rx_ready is masked by reset so every output reads 0 while it is held.
   assign rx_ready        = rx_open & ~reset;
   assign bus_req_read    = req.rd;
   assign bus_req_write   = req.wr;
   assign bus_req_address = req.addr;
   assign bus_req_data    = req.data;
   assign state           = state_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ash_d   = ash_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      is_wr_d = is_wr_q;
      case (state_q)
         ST_START: begin
            if (rx_valid) begin
               bcnt_d = 3'd0;
               case (rx_data)
                  CMD_ADDR:  state_d = ST_ADDR;
                  CMD_READ: begin
                     is_wr_d = 1'b0;
                     state_d = ST_LEN;
                  end
                  CMD_WRITE: begin
                     is_wr_d = 1'b1;
                     state_d = ST_LEN;
                  end
                  CMD_ID:    state_d = ST_ID;
                  default:   ;
               endcase
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               ash_d[{bcnt_q, 3'b000} +: 8] = rx_data;
               if (bcnt_q == AB_LAST) begin
                  addr_d  = ash_d;
                  bcnt_d  = 3'd0;
                  state_d = ST_START;
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               cnt_d   = rx_data;
               bcnt_d  = 3'd0;
               state_d = is_wr_q ? ST_WDATA : ST_RREQ;
            end
         end
         ST_WDATA: begin
            if (rx_valid) begin
               buf_d[{bcnt_q, 3'b000} +: 8] = rx_data;
               if (bcnt_q == DB_LAST) begin
                  bcnt_d  = 3'd0;
                  state_d = ST_WREQ;
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
         end
         ST_WREQ: begin
            if (bus_req_ready) begin
               addr_d = addr_q + ADDR_STEP;
               if (cnt_q == 8'd0) begin
                  state_d = (ACK_WRITES != 0) ? ST_ACK : ST_START;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
                  state_d = ST_WDATA;
               end
            end
         end
         ST_RREQ: begin
            if (bus_req_ready) begin
               addr_d  = addr_q + ADDR_STEP;
               state_d = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (bus_res_valid) begin
               buf_d   = bus_res_data;
               bcnt_d  = 3'd0;
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            // Shift on completion so the next byte is presented without a bubble.
            if (tx_ready) begin
               buf_d = buf_q >> 8;
               if (bcnt_q == DB_LAST) begin
                  bcnt_d = 3'd0;
                  if (cnt_q == 8'd0) begin
                     state_d = ST_START;
                  end else begin
                     cnt_d   = cnt_q - 8'd1;
                     state_d = ST_RREQ;
                  end
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
         end
         ST_ACK: begin
            if (tx_ready) state_d = ST_START;
         end
         ST_ID: begin
            if (tx_ready) begin
               if (bcnt_q == 3'd1) begin
                  bcnt_d  = 3'd0;
                  state_d = ST_START;
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
         end
         default: state_d = ST_START;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_START;
         addr_q  <= '0;
         ash_q   <= '0;
         buf_q   <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         is_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ash_q   <= ash_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         is_wr_q <= is_wr_d;
      end
   end

endmodule

// File: tb/tb_htif_burst.sv
// Scoreboard bench for htif_burst: stimulus pushes expected bus requests,
// tx bytes and probes; one monitor process pops and compares them.
module tb_htif_burst;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_ready;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        bus_req_ready = 1'b0;
   logic        bus_req_read;
   logic        bus_req_write;
   logic [31:0] bus_req_address;
   logic [31:0] bus_req_data;
   logic        bus_res_valid = 1'b0;
   logic [31:0] bus_res_data = 32'h0;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic [3:0]  dut_state;

   htif_burst #(.DATA_BYTES(4), .ADDR_BYTES(4), .ACK_WRITES(1)) dut (
      .clock(clock), .reset(reset),
      .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
      .bus_req_ready(bus_req_ready), .bus_req_read(bus_req_read),
      .bus_req_write(bus_req_write), .bus_req_address(bus_req_address),
      .bus_req_data(bus_req_data), .bus_res_valid(bus_res_valid),
      .bus_res_data(bus_res_data), .tx_ready(tx_ready), .tx_valid(tx_valid),
      .tx_data(tx_data), .state(dut_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } bexp_t;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } probe_t;

   localparam int P_OUTS = 0, P_ADDR = 1, P_WDATA = 2, P_QLEN = 3;

   bexp_t       exp_bus[$];
   logic [7:0]  exp_tx[$];
   probe_t      probe_q[$];
   logic [31:0] rdq[$];

   int errors = 0;
   int checks = 0;
   int tx_seen = 0;

   // bus agent / tx_ready controls, written by the stimulus process
   int stall_n = 0;
   int rsp_delay = 2;
   int stray_req = 0;
   bit tx_toggle = 1'b0;

   // ---------------- bus slave model ----------------
   int wcnt = 0, rtim = 0, stray_done = 0;
   bit acc_pend = 1'b0, acc_rd = 1'b0;
   always @(posedge clock) begin
      #1;
      bus_res_valid = 1'b0;
      if (reset) begin
         bus_req_ready = 1'b0;
         acc_pend = 1'b0;
         rtim = 0;
         wcnt = 0;
      end else begin
         if (acc_pend) begin
            acc_pend = 1'b0;
            bus_req_ready = 1'b0;
            wcnt = 0;
            if (acc_rd) rtim = rsp_delay;
         end
         if (rtim > 0) begin
            rtim--;
            if (rtim == 0) begin
               bus_res_valid = 1'b1;
               bus_res_data = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
            end
         end else if (stray_done != stray_req) begin
            stray_done = stray_req;
            bus_res_valid = 1'b1;
            bus_res_data = 32'hBAD0BAD0;
         end
         if ((bus_req_read | bus_req_write) && !bus_req_ready) begin
            if (wcnt < stall_n) wcnt++;
            else begin
               bus_req_ready = 1'b1;
               acc_pend = 1'b1;
               acc_rd = bus_req_read;
            end
         end
      end
   end

   always @(posedge clock) begin
      #1;
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   probe_t      pr;
   bexp_t       be;
   logic [63:0] pval;
   bit          bus_pend = 1'b0, tx_pend = 1'b0;
   logic [33:0] sv_ctl;
   logic [31:0] sv_data;
   logic [7:0]  sv_tx;

   always @(negedge clock) begin
      while (probe_q.size() > 0) begin
         pr = probe_q.pop_front();
         case (pr.sel)
            P_OUTS:  pval = 64'({rx_ready, bus_req_read, bus_req_write, tx_valid, tx_data, dut_state});
            P_ADDR:  pval = 64'(bus_req_address);
            P_WDATA: pval = 64'(bus_req_data);
            default: pval = 64'(exp_tx.size() + exp_bus.size());
         endcase
         chk(pr.name, pval, pr.exp);
      end
      if (reset) begin
         bus_pend = 1'b0;
         tx_pend = 1'b0;
      end else begin
         if (bus_pend) begin
            chk("bus_hold_ctl", 64'({bus_req_read, bus_req_write, bus_req_address}), 64'(sv_ctl));
            chk("bus_hold_data", 64'(bus_req_data), 64'(sv_data));
         end
         bus_pend = 1'b0;
         if ((bus_req_read | bus_req_write) && bus_req_ready) begin
            if (exp_bus.size() == 0) begin
               checks++; errors++;
               $display("FAIL bus_unexpected: got rd=%b wr=%b addr %h expected no request",
                        bus_req_read, bus_req_write, bus_req_address);
            end else begin
               be = exp_bus.pop_front();
               chk("bus_kind", 64'({bus_req_read, bus_req_write}), be.wr ? 64'd1 : 64'd2);
               chk("bus_addr", 64'(bus_req_address), 64'(be.addr));
               if (be.wr) chk("bus_wdata", 64'(bus_req_data), 64'(be.data));
            end
         end else if (bus_req_read | bus_req_write) begin
            bus_pend = 1'b1;
            sv_ctl = {bus_req_read, bus_req_write, bus_req_address};
            sv_data = bus_req_data;
         end

         if (tx_pend) chk("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, sv_tx}));
         tx_pend = 1'b0;
         if (tx_valid && tx_ready) begin
            tx_seen++;
            if (exp_tx.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
            end else begin
               chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
         end else if (tx_valid) begin
            tx_pend = 1'b1;
            sv_tx = tx_data;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic probe(input string name, input int sel, input logic [63:0] exp);
      probe_t p;
      p.name = name; p.sel = sel; p.exp = exp;
      probe_q.push_back(p);
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data = b;
      forever begin
         @(negedge clock);
         if (rx_ready) break;
         n++;
         if (n > 300) begin
            $display("FAIL rx_timeout: byte %h never accepted", b);
            $fatal(1, "stopped");
         end
      end
      @(posedge clock); #1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic sendv(input logic [7:0] v[]);
      foreach (v[i]) send(v[i]);
   endtask

   task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
      bexp_t e;
      e.wr = 1'b1; e.addr = a; e.data = d;
      exp_bus.push_back(e);
   endtask

   task automatic exp_r(input logic [31:0] a, input logic [31:0] d);
      bexp_t e;
      e.wr = 1'b0; e.addr = a; e.data = 32'h0;
      exp_bus.push_back(e);
      rdq.push_back(d);
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_tx.size() != 0 || exp_bus.size() != 0) begin
         @(posedge clock); #1;
         n++;
         if (n > 1000) begin
            $display("FAIL drain_timeout: tx_left=%0d bus_left=%0d expected 0",
                     exp_tx.size(), exp_bus.size());
            $fatal(1, "stopped");
         end
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      int base;
      #3;
      probe("rst_outs", P_OUTS, 64'h0);
      probe("rst_addr", P_ADDR, 64'h0);
      probe("rst_wdata", P_WDATA, 64'h0);
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      @(posedge clock); #1;
      probe("idle_outs", P_OUTS, 64'h8000);

      // address load, no bus traffic
      sendv('{8'h61, 8'h00, 8'h10, 8'h00, 8'h00});
      probe("addr_load", P_ADDR, 64'h1000);
      probe("addr_idle", P_OUTS, 64'h8000);
      @(posedge clock); #1;

      // two-word write burst with stalled bus, then ack byte
      stall_n = 3;
      exp_w(32'h1000, 32'h44332211);
      exp_w(32'h1004, 32'h88776655);
      exp_tx.push_back(8'h6B);
      sendv('{8'h77, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
      drain();
      probe("wr_final_addr", P_ADDR, 64'h1008);
      stall_n = 0;
      @(posedge clock); #1;

      // single read, late response, tx_ready toggling
      rsp_delay = 5;
      tx_toggle = 1'b1;
      exp_r(32'h1008, 32'hDEADBEEF);
      sendv('{8'h72, 8'h00});
      drain();
      tx_toggle = 1'b0;
      probe("rd_final_addr", P_ADDR, 64'h100C);
      @(posedge clock); #1;

      // address wrap across two-word read
      rsp_delay = 2;
      sendv('{8'h61, 8'hFC, 8'hFF, 8'hFF, 8'hFF});
      probe("wrap_addr_load", P_ADDR, 64'hFFFFFFFC);
      exp_r(32'hFFFFFFFC, 32'h11223344);
      exp_r(32'h00000000, 32'h55667788);
      sendv('{8'h72, 8'h01});
      drain();
      probe("wrap_final_addr", P_ADDR, 64'h4);
      @(posedge clock); #1;

      // identify, then an unknown byte that must be ignored
      exp_tx.push_back(8'h04);
      exp_tx.push_back(8'h04);
      send(8'h3F);
      drain();
      send(8'h5A);
      repeat (5) @(posedge clock);
      #1;
      probe("ignored_outs", P_OUTS, 64'h8000);
      @(posedge clock); #1;

      // reset in the middle of a 3-word read while tx is on byte 2
      sendv('{8'h61, 8'h00, 8'h20, 8'h00, 8'h00});
      exp_r(32'h2000, 32'h04030201);
      exp_r(32'h2004, 32'h08070605);
      exp_r(32'h2008, 32'h0C0B0A09);
      base = tx_seen;
      sendv('{8'h72, 8'h02});
      for (int n = 0; tx_seen < base + 2; n++) begin
         @(posedge clock); #2;
         if (n > 300) begin
            $display("FAIL tx_progress_timeout: seen=%0d expected %0d", tx_seen - base, 2);
            $fatal(1, "stopped");
         end
      end
      reset = 1'b1;
      #1;
      probe("midrst_outs", P_OUTS, 64'h0);
      probe("midrst_addr", P_ADDR, 64'h0);
      probe("midrst_wdata", P_WDATA, 64'h0);
      exp_tx.delete();
      exp_bus.delete();
      rdq.delete();
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      stray_req++;
      repeat (6) @(posedge clock);
      #1;
      probe("stray_ignored", P_OUTS, 64'h8000);
      sendv('{8'h61, 8'h00, 8'h30, 8'h00, 8'h00});
      probe("post_rst_addr", P_ADDR, 64'h3000);
      probe("queues_empty", P_QLEN, 64'h0);
      @(posedge clock);
      @(negedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
